context_switch_unit: RTL
========================

# context_switch_unit

Responder side of the scheduling handshake. It consumes the quantum-expiry, I/O-trap and process-end requests raised by the quantum counter and keeps a per-process table of PC and state. It picks the next ready process round-robin and drives the PC-load port of the fetch stage. It sits between the quantum counter and the PC register. The OS (PID 0) uses it to create processes and to wake processes blocked on I/O.

## Interface
- NPROC, 8, table entries; PID 0 = OS, PIDs 1..NPROC-1 = user processes
- PID_W, 3, PID width, equal to clog2(NPROC)
- OS_PC, 32'h0, OS idle-loop entry, loaded when no process is ready
- IO_PC, 32'h40, OS I/O-handler entry

- clock  in  1  all state updates on posedge
- reset  in  1  reset reset, asynchronous, active-high
- switch_req  in  1  quantum expired; level, held by the initiator until cmd_ready
- io_req  in  1  current process issued an I/O instruction
- exit_req  in  1  current process finished
- saved_pc  in  32  resume PC of the interrupted process, already +1
- create_valid  in  1  OS creates a process
- create_pid  in  PID_W  PID of the new process
- create_pc  in  32  start PC of the new process
- wake_valid  in  1  I/O complete
- wake_pid  in  PID_W  PID to unblock
- cmd_ready  out  1  high in IDLE; inputs are sampled only when it is high
- busy  out  1  high in SAVE, SELECT and LOAD
- pc_load  out  1  one-cycle pulse; the PC register takes pc_next
- pc_next  out  32  PC to load
- current_pid  out  PID_W  running PID
- no_ready  out  1  last selection found no ready process

## Operation
- Each table entry holds pc[31:0] and a state: FREE, READY, BLOCKED or RUNNING.
- FSM states are IDLE, SAVE, SELECT and LOAD.
- IDLE, with current_pid != 0, uses priority exit_req > io_req > switch_req:
  - exit_req: entry[cur] becomes FREE, then go to SAVE.
  - io_req: entry[cur] gets pc = saved_pc and becomes BLOCKED, then go to SAVE.
  - switch_req: entry[cur] gets pc = saved_pc and becomes READY, then go to SAVE.
- IDLE, with current_pid == 0:
  - switch_req means dispatch. OS PC is not saved.
  - io_req and exit_req are ignored.
- Create and wake are honoured in IDLE only when no req is pending:
  - create: entry[pid] gets pc = create_pc and becomes READY.
  - wake: a BLOCKED entry becomes READY. Waking a non-BLOCKED entry is a no-op.
  - create and wake with the same PID in the same cycle: create wins.
  - create_pid 0 or wake_pid 0 is ignored.
- SAVE: the table write commits. The request kind is latched.
- SELECT:
  - If the latched kind is io, the target is PID 0 at IO_PC.
  - Otherwise, the round-robin search starts at cur+1 and wraps across 1..NPROC-1, ending at cur inclusive. The first READY entry wins.
  - If no entry is READY, the target is PID 0 at OS_PC and no_ready is set.
- LOAD:
  - pc_load = 1, pc_next = target PC, current_pid = target.
  - A user target becomes RUNNING.
  - no_ready clears on any successful user selection.
  - Next state is IDLE.
- Wrap-around: cur = NPROC-1 continues the search at PID 1, never at 0.

## Timing
- Request seen in IDLE at edge t:
  - SAVE at t+1
  - SELECT at t+2
  - LOAD, with pc_load high for one cycle, at t+3
  - IDLE at t+4
- Fixed latency of 3 cycles, independent of NPROC. The selector is combinational.
- Requests arriving while busy are not sampled. The initiator holds them and they are taken at t+4.
- Reset values:
  - every entry FREE with pc 0
  - FSM in IDLE
  - current_pid = 0, pc_next = OS_PC
  - pc_load, busy, no_ready = 0
  - cmd_ready = 1
- Reset mid-operation aborts the sequence. No pc_load pulse is emitted.

## Structure
- Package ctx_pkg holds:
  - pid_t
  - proc_state_e (FREE, READY, BLOCKED, RUNNING)
  - fsm_e
  - req_kind_e (SWITCH, IO, EXIT)
  - defaults for OS_PC and IO_PC
- Sub-module rr_pick: a combinational round-robin finder.
  - Inputs: ready vector and start PID.
  - Outputs: found and pid.

## Test plan
- Create PIDs 1 (pc 0x100) and 2 (pc 0x200); switch_req from PID 0 -> after 3 cycles pc_load=1, pc_next=0x100, current_pid=1.
- PID 1 running, switch_req with saved_pc=0x105 -> pc_next=0x200, pid 2; next switch_req with saved_pc=0x20A -> pc_next=0x105, pid 1.
- PID 1 io_req with saved_pc=0x107 -> pc_next=IO_PC, pid 0, entry 1 BLOCKED; wake_pid=1, then switch_req -> pc_next=0x107 if PID 1 is the only READY entry.
- Only PID 7 live, exit_req -> pc_next=OS_PC, pid 0, no_ready=1; a later switch_req with an empty table keeps no_ready=1.
- exit_req and switch_req asserted together -> exit is taken and the entry becomes FREE; requests held during busy are accepted exactly at t+4.
- Reset asserted in SELECT -> no pc_load, all outputs at reset values, table cleared.

Source files
------------

// File: rtl/ctx_pkg.sv
// rtl/ctx_pkg.sv - shared types and constants for the context switch unit
package ctx_pkg;

    localparam int          NPROC = 8;
    localparam int          PID_W = $clog2(NPROC);
    localparam logic [31:0] OS_PC = 32'h0000_0000;
    localparam logic [31:0] IO_PC = 32'h0000_0040;

    typedef logic [PID_W-1:0] pid_t;

    typedef enum logic [1:0] {FREE, READY, BLOCKED, RUNNING} proc_state_e;
    typedef enum logic [1:0] {IDLE, SAVE, SELECT, LOAD}      fsm_e;
    typedef enum logic [1:0] {SWITCH, IO, EXIT}              req_kind_e;

endpackage

// File: rtl/context_switch_unit_if.sv
// rtl/context_switch_unit_if.sv - scheduling handshake and PC-load bundle
interface context_switch_unit_if;
    import ctx_pkg::*;

    logic        switch_req;
    logic        io_req;
    logic        exit_req;
    logic [31:0] saved_pc;
    logic        create_valid;
    pid_t        create_pid;
    logic [31:0] create_pc;
    logic        wake_valid;
    pid_t        wake_pid;
    logic        cmd_ready;
    logic        busy;
    logic        pc_load;
    logic [31:0] pc_next;
    pid_t        current_pid;
    logic        no_ready;

    modport master (
        output switch_req, io_req, exit_req, saved_pc,
        output create_valid, create_pid, create_pc, wake_valid, wake_pid,
        input  cmd_ready, busy, pc_load, pc_next, current_pid, no_ready
    );

    modport slave (
        input  switch_req, io_req, exit_req, saved_pc,
        input  create_valid, create_pid, create_pc, wake_valid, wake_pid,
        output cmd_ready, busy, pc_load, pc_next, current_pid, no_ready
    );

endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin finder over user PIDs 1..NPROC-1
module rr_pick
    import ctx_pkg::*;
(
    input  logic [NPROC-1:0] i_ready,
    input  pid_t             i_start,
    output logic             o_found,
    output pid_t             o_pid
);

    // First ready PID scanning upward from i_start; PID 0 is never a candidate
    always_comb begin
        int   base;
        pid_t idx;
        o_found = 1'b0;
        o_pid   = '0;
        base    = (i_start == '0) ? 0 : int'(i_start) - 1;
        idx     = '0;
        for (int k = 0; k < NPROC - 1; k++) begin
            idx = PID_W'(((base + k) % (NPROC - 1)) + 1);
            if (!o_found && i_ready[idx]) begin
                o_found = 1'b1;
                o_pid   = idx;
            end
        end
    end

endmodule

// File: rtl/context_switch_unit.sv
// rtl/context_switch_unit.sv - process table, request sequencer and PC-load driver
module context_switch_unit
    import ctx_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    context_switch_unit_if.slave bus
);

    logic [31:0] r_pc [NPROC];
    proc_state_e r_st [NPROC];

    fsm_e        r_fsm;
    pid_t        r_cur;
    logic [31:0] r_pc_next;
    logic        r_pc_load;
    logic        r_busy;
    logic        r_cmd_ready;
    logic        r_no_ready;
    req_kind_e   r_kind;
    logic        r_wr_en;
    proc_state_e r_wr_state;
    logic [31:0] r_wr_pc;

    logic [NPROC-1:0] w_ready;
    pid_t             w_start;
    logic             w_found;
    pid_t             w_pid;
    logic             w_user;
    logic             w_take;

    assign w_user = (r_cur != '0);
    assign w_take = bus.switch_req | (w_user & (bus.io_req | bus.exit_req));

    // Ready vector and search start: one past the running PID, skipping PID 0
    always_comb begin
        w_ready = '0;
        for (int i = 0; i < NPROC; i++) begin
            w_ready[i] = (r_st[i] == READY);
        end
        w_start = (r_cur == pid_t'(NPROC - 1)) ? pid_t'(1) : r_cur + pid_t'(1);
    end

    rr_pick u_rr_pick (
        .i_ready (w_ready),
        .i_start (w_start),
        .o_found (w_found),
        .o_pid   (w_pid)
    );

    // Sequencer: accept in IDLE, commit table write, select target, pulse pc_load
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NPROC; i++) begin
                r_pc[i] <= '0;
                r_st[i] <= FREE;
            end
            r_fsm       <= IDLE;
            r_cur       <= '0;
            r_pc_next   <= OS_PC;
            r_pc_load   <= 1'b0;
            r_busy      <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_no_ready  <= 1'b0;
            r_kind      <= SWITCH;
            r_wr_en     <= 1'b0;
            r_wr_state  <= FREE;
            r_wr_pc     <= '0;
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (w_take) begin
                        r_fsm       <= SAVE;
                        r_busy      <= 1'b1;
                        r_cmd_ready <= 1'b0;
                        r_wr_en     <= w_user;
                        if (w_user && bus.exit_req) begin
                            r_kind     <= EXIT;
                            r_wr_state <= FREE;
                            r_wr_pc    <= r_pc[r_cur];
                        end else if (w_user && bus.io_req) begin
                            r_kind     <= IO;
                            r_wr_state <= BLOCKED;
                            r_wr_pc    <= bus.saved_pc;
                        end else begin
                            r_kind     <= SWITCH;
                            r_wr_state <= READY;
                            r_wr_pc    <= bus.saved_pc;
                        end
                    end else begin
                        if (bus.wake_valid && bus.wake_pid != '0 && r_st[bus.wake_pid] == BLOCKED) begin
                            r_st[bus.wake_pid] <= READY;
                        end
                        // Later assignment lets create win over a same-PID wake
                        if (bus.create_valid && bus.create_pid != '0) begin
                            r_pc[bus.create_pid] <= bus.create_pc;
                            r_st[bus.create_pid] <= READY;
                        end
                    end
                end
                SAVE: begin
                    if (r_wr_en) begin
                        r_pc[r_cur] <= r_wr_pc;
                        r_st[r_cur] <= r_wr_state;
                    end
                    r_fsm <= SELECT;
                end
                SELECT: begin
                    r_fsm     <= LOAD;
                    r_pc_load <= 1'b1;
                    if (r_kind == IO) begin
                        r_cur     <= '0;
                        r_pc_next <= IO_PC;
                    end else if (w_found) begin
                        r_cur       <= w_pid;
                        r_pc_next   <= r_pc[w_pid];
                        r_st[w_pid] <= RUNNING;
                        r_no_ready  <= 1'b0;
                    end else begin
                        r_cur      <= '0;
                        r_pc_next  <= OS_PC;
                        r_no_ready <= 1'b1;
                    end
                end
                LOAD: begin
                    r_pc_load   <= 1'b0;
                    r_busy      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_fsm       <= IDLE;
                end
                default: r_fsm <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready   = r_cmd_ready;
    assign bus.busy        = r_busy;
    assign bus.pc_load     = r_pc_load;
    assign bus.pc_next     = r_pc_next;
    assign bus.current_pid = r_cur;
    assign bus.no_ready    = r_no_ready;

endmodule
